// File: rtl/usi_pkg.sv
// rtl/usi_pkg.sv - shared encodings for the UltraSimpleInterface bus router
package usi_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_WR   = 2'd1,
    CMD_RD   = 2'd2,
    CMD_RSV  = 2'd3
  } usi_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } usi_state_e;

  localparam int USI_CMD_MSB    = 31;
  localparam int USI_CMD_LSB    = 30;
  localparam int USI_BUS_MSB    = 23;
  localparam int USI_BUS_LSB    = 16;
  localparam int USI_MAX_SLAVES = 16;
  localparam int USI_IDX_W      = $clog2(USI_MAX_SLAVES);

  localparam logic [31:0] USI_ERR_DATA = 32'h1234_5678;

endpackage

// File: rtl/usi_adrs_decode.sv
// rtl/usi_adrs_decode.sv - bus address to one-hot slave select, hit flag and index
module usi_adrs_decode
  import usi_pkg::*;
#(
  parameter int          pBusNum   = 9,
  parameter logic [7:0]  pBaseAdrs = 8'h01
) (
  input  logic [7:0]           bus_adrs_i,
  output logic [pBusNum-1:0]   sel_o,
  output logic                 hit_o,
  output logic [USI_IDX_W-1:0] idx_o
);

  logic [8:0] diff;

  // 9-bit arithmetic keeps addresses below the base from wrapping into range
  always_comb begin
    diff  = {1'b0, bus_adrs_i} - {1'b0, pBaseAdrs};
    hit_o = ({1'b0, bus_adrs_i} >= {1'b0, pBaseAdrs}) && (diff < 9'(pBusNum));
    idx_o = hit_o ? diff[USI_IDX_W-1:0] : '0;
    sel_o = '0;
    for (int i = 0; i < pBusNum; i++) begin
      if (hit_o && (idx_o == USI_IDX_W'(i))) sel_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/usi_bus_router.sv
// rtl/usi_bus_router.sv - one master to pBusNum CSR slaves, single outstanding read with timeout
module usi_bus_router
  import usi_pkg::*;
#(
  parameter int          pBusNum   = 9,
  parameter logic [7:0]  pBaseAdrs = 8'h01,
  parameter int          pTimeout  = 255,
  parameter logic [31:0] pErrData  = USI_ERR_DATA
) (
  input  logic                    iUsiClk,
  input  logic                    iUsiRstn,
  input  logic [31:0]             iMUsiWd,
  input  logic [31:0]             iMUsiAdrs,
  input  logic                    iMUsiWCke,
  output logic                    oMUsiRdy,
  output logic [31:0]             oMUsiRd,
  output logic                    oMUsiRdVd,
  output logic                    oMUsiErr,
  output logic [31:0]             oSUsiWd,
  output logic [31:0]             oSUsiAdrs,
  output logic [pBusNum-1:0]      oSUsiWCke,
  input  logic [32*pBusNum-1:0]   iSUsiRd,
  input  logic [pBusNum-1:0]      iSUsiVd
);

  localparam int CNTW = $clog2(pTimeout + 1);

  usi_state_e           state_q, state_d;
  logic                 rdy_q, rdvd_q;
  logic                 err_q, err_d;
  logic [31:0]          rd_q, rd_d;
  logic [31:0]          wd_q, wd_d;
  logic [31:0]          adrs_q, adrs_d;
  logic [pBusNum-1:0]   wcke_q, wcke_d;
  logic [USI_IDX_W-1:0] idx_q, idx_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  usi_cmd_e             cmd;
  logic                 accept;
  logic                 dec_hit;
  logic [USI_IDX_W-1:0] dec_idx;
  logic [pBusNum-1:0]   dec_sel;
  logic                 slv_vd;
  logic [31:0]          slv_rd;

  assign cmd    = usi_cmd_e'(iMUsiAdrs[USI_CMD_MSB:USI_CMD_LSB]);
  assign accept = iMUsiWCke & rdy_q;

  usi_adrs_decode #(
    .pBusNum   (pBusNum),
    .pBaseAdrs (pBaseAdrs)
  ) u_decode (
    .bus_adrs_i (iMUsiAdrs[USI_BUS_MSB:USI_BUS_LSB]),
    .sel_o      (dec_sel),
    .hit_o      (dec_hit),
    .idx_o      (dec_idx)
  );

  // Only the slave that owns the outstanding read is listened to
  always_comb begin
    slv_vd = 1'b0;
    slv_rd = '0;
    for (int i = 0; i < pBusNum; i++) begin
      if (idx_q == USI_IDX_W'(i)) begin
        slv_vd = iSUsiVd[i];
        slv_rd = iSUsiRd[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    wd_d    = wd_q;
    adrs_d  = adrs_q;
    wcke_d  = '0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_WR: begin
              if (dec_hit) begin
                wd_d   = iMUsiWd;
                adrs_d = iMUsiAdrs;
                wcke_d = dec_sel;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_RD: begin
              if (dec_hit) begin
                wd_d    = iMUsiWd;
                adrs_d  = iMUsiAdrs;
                wcke_d  = dec_sel;
                idx_d   = dec_idx;
                cnt_d   = '0;
                state_d = ST_WAIT;
              end else begin
                rd_d    = pErrData;
                err_d   = 1'b1;
                state_d = ST_RESP;
              end
            end
            CMD_RSV: begin
              rd_d    = pErrData;
              err_d   = 1'b1;
              state_d = ST_RESP;
            end
            CMD_NONE: ;
          endcase
        end
      end
      ST_WAIT: begin
        // Valid data takes priority over a timeout landing in the same cycle
        if (slv_vd) begin
          rd_d    = slv_rd;
          state_d = ST_RESP;
        end else if ((32'(cnt_q) + 32'd1) >= 32'(pTimeout)) begin
          rd_d    = pErrData;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iUsiClk or negedge iUsiRstn) begin
    if (!iUsiRstn) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      rdvd_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
      adrs_q  <= '0;
      wcke_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      rdvd_q  <= (state_d == ST_RESP);
      err_q   <= err_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      adrs_q  <= adrs_d;
      wcke_q  <= wcke_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oMUsiRdy  = rdy_q;
  assign oMUsiRd   = rd_q;
  assign oMUsiRdVd = rdvd_q;
  assign oMUsiErr  = err_q;
  assign oSUsiWd   = wd_q;
  assign oSUsiAdrs = adrs_q;
  assign oSUsiWCke = wcke_q;

endmodule

// File: tb/tb_usi_bus_router.sv
// tb/tb_usi_bus_router.sv - scoreboard bench for usi_bus_router
module tb_usi_bus_router;

  localparam int          NB   = 9;
  localparam logic [31:0] ERRW = 32'h1234_5678;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [31:0]      iMUsiWd = '0;
  logic [31:0]      iMUsiAdrs = '0;
  logic             iMUsiWCke = 1'b0;
  logic             oMUsiRdy;
  logic [31:0]      oMUsiRd;
  logic             oMUsiRdVd;
  logic             oMUsiErr;
  logic [31:0]      oSUsiWd;
  logic [31:0]      oSUsiAdrs;
  logic [NB-1:0]    oSUsiWCke;
  logic [32*NB-1:0] iSUsiRd = '0;
  logic [NB-1:0]    iSUsiVd = '0;

  always #5 clk = ~clk;

  usi_bus_router #(
    .pBusNum   (NB),
    .pBaseAdrs (8'h01),
    .pTimeout  (4),
    .pErrData  (ERRW)
  ) dut (
    .iUsiClk   (clk),
    .iUsiRstn  (rstn),
    .iMUsiWd   (iMUsiWd),
    .iMUsiAdrs (iMUsiAdrs),
    .iMUsiWCke (iMUsiWCke),
    .oMUsiRdy  (oMUsiRdy),
    .oMUsiRd   (oMUsiRd),
    .oMUsiRdVd (oMUsiRdVd),
    .oMUsiErr  (oMUsiErr),
    .oSUsiWd   (oSUsiWd),
    .oSUsiAdrs (oSUsiAdrs),
    .oSUsiWCke (oSUsiWCke),
    .iSUsiRd   (iSUsiRd),
    .iSUsiVd   (iSUsiVd)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [NB-1:0] sel;
    logic [31:0]   wd;
    logic [7:0]    bus;
  } stb_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  bit   errp_q[$];
  stb_t se;
  rsp_t re;

  always @(negedge clk) begin
    if (rstn) begin
      if (oSUsiWCke != '0) begin
        if (stb_q.size() == 0) check("unexpected_strobe", 64'(oSUsiWCke), 64'(0));
        else begin
          se = stb_q.pop_front();
          check("strobe", 64'(oSUsiWCke), 64'(se.sel));
          check("strobe_wd", 64'(oSUsiWd), 64'(se.wd));
          check("strobe_bus", 64'(oSUsiAdrs[23:16]), 64'(se.bus));
        end
      end
      if (oMUsiRdVd) begin
        if (rsp_q.size() == 0) check("unexpected_rdvd", 64'(oMUsiRdVd), 64'(0));
        else begin
          re = rsp_q.pop_front();
          check("rsp_data", 64'(oMUsiRd), 64'(re.rd));
          check("rsp_err", 64'(oMUsiErr), 64'(re.err));
        end
      end else if (oMUsiErr) begin
        if (errp_q.size() == 0) check("unexpected_err", 64'(oMUsiErr), 64'(0));
        else void'(errp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [1:0] cmd, input logic [7:0] bus, input logic [31:0] wd);
    int   g;
    logic hit;
    int   idx;
    stb_t s;
    rsp_t r;
    g = 0;
    while (!oMUsiRdy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!oMUsiRdy) check("rdy_wait_timeout", 64'(oMUsiRdy), 64'(1));
    hit = (bus >= 8'h01) && (bus < 8'h0A);
    idx = int'(bus) - 1;
    if ((cmd == 2'd1 || cmd == 2'd2) && hit) begin
      s.sel = NB'(1) << idx;
      s.wd  = wd;
      s.bus = bus;
      stb_q.push_back(s);
    end
    if (cmd == 2'd1 && !hit) errp_q.push_back(1'b1);
    if ((cmd == 2'd2 && !hit) || cmd == 2'd3) begin
      r.rd  = ERRW;
      r.err = 1'b1;
      rsp_q.push_back(r);
    end
    iMUsiAdrs = {cmd, 6'b0, bus, 16'h0042};
    iMUsiWd   = wd;
    iMUsiWCke = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iMUsiWCke = 1'b0;
    iMUsiAdrs = '0;
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic err);
    rsp_t r;
    r.rd  = rd;
    r.err = err;
    rsp_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_rdy", 64'(oMUsiRdy), 64'(0));
    check("rst_rdvd", 64'(oMUsiRdVd), 64'(0));
    check("rst_err", 64'(oMUsiErr), 64'(0));
    check("rst_wcke", 64'(oSUsiWCke), 64'(0));
    check("rst_rd", 64'(oMUsiRd), 64'(0));
    rstn = 1'b1;
    #1 check("rdy_before_edge", 64'(oMUsiRdy), 64'(0));
    @(negedge clk);
    check("rdy_after_edge", 64'(oMUsiRdy), 64'(1));

    send(2'd1, 8'h03, 32'hA5A5_0001);
    check("wr_strobe_onehot", 64'(oSUsiWCke), 64'(9'b000000100));
    @(negedge clk);
    check("wr_strobe_one_cycle", 64'(oSUsiWCke), 64'(0));

    send(2'd1, 8'h01, 32'h0000_1001);
    check("b2b_rdy0", 64'(oMUsiRdy), 64'(1));
    send(2'd1, 8'h05, 32'h0000_1005);
    check("b2b_rdy1", 64'(oMUsiRdy), 64'(1));
    send(2'd1, 8'h09, 32'h0000_1009);
    check("b2b_rdy2", 64'(oMUsiRdy), 64'(1));

    expect_rsp(32'hCAFE_0007, 1'b0);
    send(2'd2, 8'h07, 32'h0);
    check("rd_rdy_low0", 64'(oMUsiRdy), 64'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rd_rdy_low", 64'(oMUsiRdy), 64'(0));
      check("rd_no_rdvd", 64'(oMUsiRdVd), 64'(0));
    end
    iSUsiVd[6] = 1'b1;
    iSUsiRd[6*32 +: 32] = 32'hCAFE_0007;
    @(negedge clk);
    check("rd_rdvd", 64'(oMUsiRdVd), 64'(1));
    check("rd_rdy_resp", 64'(oMUsiRdy), 64'(0));
    iSUsiVd = '0;
    @(negedge clk);
    check("rd_rdy_back", 64'(oMUsiRdy), 64'(1));
    check("rd_rdvd_pulse", 64'(oMUsiRdVd), 64'(0));
    check("rd_hold", 64'(oMUsiRd), 64'(32'hCAFE_0007));

    send(2'd2, 8'h0A, 32'h0);
    check("unmapped_rdvd", 64'(oMUsiRdVd), 64'(1));
    check("unmapped_no_strobe", 64'(oSUsiWCke), 64'(0));
    send(2'd1, 8'h00, 32'h0000_BAD0);
    check("wr_miss_err", 64'(oMUsiErr), 64'(1));
    check("wr_miss_no_rdvd", 64'(oMUsiRdVd), 64'(0));

    expect_rsp(ERRW, 1'b1);
    send(2'd2, 8'h02, 32'h0);
    iSUsiVd[0] = 1'b1;
    iSUsiRd[31:0] = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tmo_wait", 64'(oMUsiRdVd), 64'(0));
    end
    @(negedge clk);
    check("tmo_rdvd", 64'(oMUsiRdVd), 64'(1));
    iSUsiVd = '0;

    expect_rsp(32'hBEEF_0004, 1'b0);
    send(2'd2, 8'h04, 32'h0);
    iSUsiVd[3] = 1'b1;
    iSUsiRd[3*32 +: 32] = 32'hBEEF_0004;
    @(negedge clk);
    check("min_lat_rdvd", 64'(oMUsiRdVd), 64'(1));
    iSUsiVd = '0;

    expect_rsp(32'h5A5A_0009, 1'b0);
    send(2'd2, 8'h09, 32'h0);
    repeat (3) @(negedge clk);
    iSUsiVd[8] = 1'b1;
    iSUsiRd[8*32 +: 32] = 32'h5A5A_0009;
    @(negedge clk);
    check("vd_tmo_same_rdvd", 64'(oMUsiRdVd), 64'(1));
    iSUsiVd = '0;

    send(2'd3, 8'h03, 32'h0);
    check("rsv_rdvd", 64'(oMUsiRdVd), 64'(1));

    send(2'd2, 8'h05, 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_rdy", 64'(oMUsiRdy), 64'(0));
    check("mid_rst_wd", 64'(oSUsiWd), 64'(0));
    check("mid_rst_adrs", 64'(oSUsiAdrs), 64'(0));
    check("mid_rst_rd", 64'(oMUsiRd), 64'(0));
    check("mid_rst_flags", 64'({oMUsiRdVd, oMUsiErr, oSUsiWCke}), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_rdy", 64'(oMUsiRdy), 64'(1));
    expect_rsp(32'h1111_0005, 1'b0);
    send(2'd2, 8'h05, 32'h0);
    @(negedge clk);
    iSUsiVd[4] = 1'b1;
    iSUsiRd[4*32 +: 32] = 32'h1111_0005;
    @(negedge clk);
    check("post_rst_rdvd", 64'(oMUsiRdVd), 64'(1));
    iSUsiVd = '0;

    repeat (3) @(negedge clk);
    check("stb_q_empty", 64'(stb_q.size()), 64'(0));
    check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    check("errp_q_empty", 64'(errp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/usi_bus_router.md
Name: usi_bus_router

Overview:
Next-generation UltraSimpleInterface interconnect between one bus master and up to 16 CSR slaves.
- Replaces the fixed-case read mux with a parametrised base-address decoder.
- Adds per-slave one-hot command strobes, a master ready/back-pressure signal and a single outstanding read with read-valid handshake.
- Adds a timeout that returns an error word.
- Sits between the CPU-side master and the GPIO/PWM/SPI/I2C/PGB/AGB/VDMA/ADMA/PSRAM CSR blocks.

Parameters:
pBusNum, 9, number of slaves (1..16)
pBaseAdrs, 8'h01, bus address of slave 0; slave i answers at pBaseAdrs+i
pTimeout, 255, WAIT cycles allowed before a read is aborted (1..65535)
pErrData, 32'h1234_5678, data returned on unmapped, reserved or timed-out reads

Ports:
iUsiClk  in  1  bus clock
iUsiRstn  in  1  asynchronous active-low reset
iMUsiWd  in  32  master write data
iMUsiAdrs  in  32  {31:30} cmd (0 none, 1 write, 2 read, 3 reserved), {23:16} bus address, {15:0} CSR address
iMUsiWCke  in  1  master command valid
oMUsiRdy  out  1  router can accept a command this cycle
oMUsiRd  out  32  read response data
oMUsiRdVd  out  1  one-cycle pulse: oMUsiRd valid
oMUsiErr  out  1  one-cycle pulse: unmapped, reserved or timeout
oSUsiWd  out  32  registered write data, broadcast to all slaves
oSUsiAdrs  out  32  registered address, broadcast to all slaves
oSUsiWCke  out  pBusNum  one-hot command strobe to the selected slave
iSUsiRd  in  32*pBusNum  slave read data; slave i occupies bits [32i+31:32i]
iSUsiVd  in  pBusNum  slave read-data valid, one bit per slave

Behaviour:
- Reset (iUsiRstn low, asynchronous):
  - state IDLE.
  - All outputs 0, including oMUsiRdy.
  - oMUsiRdy rises on the first iUsiClk edge after reset deasserts.
  - Reset during WAIT abandons the read with no response; a pending strobe is dropped.
- A command is accepted when iMUsiWCke and oMUsiRdy are both high at a clock edge.
- Decode: idx = adrs[23:16] - pBaseAdrs. A hit requires pBaseAdrs <= adrs[23:16] < pBaseAdrs + pBusNum. Compare in 9 bits so there is no wraparound.
- States are IDLE, WAIT and RESP.
- IDLE (oMUsiRdy = 1):
  - Write hit: oSUsiWd/oSUsiAdrs are registered. oSUsiWCke[idx] is high for exactly the next cycle. State stays IDLE, so back-to-back writes are accepted every cycle.
  - Write miss: no strobe. oMUsiErr pulses for the next cycle.
  - cmd 0: ignored, no strobe, no error.
  - Read hit: strobe as for a write. Go to WAIT, oMUsiRdy = 0, timeout counter cleared.
  - Read miss or cmd 3: go to RESP with data pErrData and error set.
- WAIT:
  - Only iSUsiVd[idx] is honoured; Vd from other slaves is ignored.
  - The first WAIT cycle coincides with the strobe cycle, and Vd is sampled from that cycle on.
  - On Vd: capture the idx data slice and go to RESP.
  - Otherwise the counter increments. When the counter reaches pTimeout, go to RESP with pErrData and error set.
  - If Vd and timeout occur in the same cycle, the data wins and there is no error.
- RESP (1 cycle):
  - oMUsiRdVd = 1, oMUsiErr = error flag, oMUsiRdy = 0.
  - Next state IDLE.
- oMUsiRd holds its last value between responses.
- Read latency: command accepted at edge k, Vd sampled at edge m (m >= k+1); oMUsiRdVd is high during cycle m+1.
- Minimum latency: Vd at k+1 gives oMUsiRdVd at k+2.
- Unmapped read latency: oMUsiRdVd is high during cycle k+1.
- All outputs are registered.
- The counter is clog2(pTimeout+1) bits wide.

Decomposition:
- Package usi_pkg holds:
  - cmd encodings (CMD_NONE/WR/RD/RSV)
  - address field positions
  - the state encoding
  - the default error word
  - the maximum slave count of 16
- Sub-module usi_adrs_decode: combinational, bus address in; one-hot select, hit and binary idx out. Parametrised by pBusNum and pBaseAdrs.

Test Plan:
- Write to 8'h03 (pBaseAdrs 1), Wd = 32'hA5A5_0001 -> oSUsiWCke = 9'b000000100 for one cycle, oSUsiWd = A5A5_0001, no oMUsiRdVd.
- Three back-to-back writes to 8'h01, 8'h05, 8'h09 -> oMUsiRdy stays 1. Strobes on bits 0, 4 and 8 in consecutive cycles.
- Read 8'h07, slave 6 raises Vd 3 cycles after its strobe with data 32'hCAFE_0007 -> oMUsiRdVd one cycle later with CAFE_0007, oMUsiErr = 0. oMUsiRdy is low from acceptance until after RESP.
- Read 8'h0A (unmapped, pBusNum 9) -> oMUsiRdVd next cycle, data 1234_5678, oMUsiErr = 1, no strobe. Write to 8'h00 -> oMUsiErr pulse only.
- Read 8'h02 with no Vd, pTimeout = 4 -> error response 1234_5678 after 4 WAIT cycles. Vd from slave 0 during WAIT is ignored.
- Assert iUsiRstn low mid-WAIT -> all outputs 0 immediately, no RdVd after release. A new read then completes normally.
